// File: rtl/uart_host_sequencer_if.sv
// Requester and UART register-bus signals of the host sequencer.
// The master modport is the sequencer's view; the slave modport is the
// view of whatever sits on the other side (requesters plus UART top).
interface uart_host_sequencer_if;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       bus_wr;
    logic       bus_rd;
    logic [2:0] bus_addr;
    logic [7:0] bus_din;
    logic [7:0] bus_dout;

    modport master (
        input  req, data0, data1, bus_dout,
        output gnt, rx_data, rx_valid, bus_wr, bus_rd, bus_addr, bus_din
    );

    modport slave (
        output req, data0, data1, bus_dout,
        input  gnt, rx_data, rx_valid, bus_wr, bus_rd, bus_addr, bus_din
    );
endinterface

// File: rtl/uart_host_sequencer.sv
// Bus master for a 16550-style UART register bus: programs the divisor,
// LCR and FCR after start, then arbitrates two byte requesters onto THR
// while tracking TX FIFO space with a credit counter refilled by LSR polls.
// Received bytes are drained whenever an LSR poll reports DR.
module uart_host_sequencer #(
    parameter logic [15:0] DIV      = 16'h0108,
    parameter logic [7:0]  LCR_VAL  = 8'h03,
    parameter logic [7:0]  FCR_VAL  = 8'h01,
    parameter int          TX_DEPTH = 16,
    parameter int          POLL_GAP = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   cfg_done,
    uart_host_sequencer_if.master  hif
);

    typedef enum logic [3:0] {
        IDLE, C_DLAB, C_DLL, C_DLM, C_LCR, C_FCR,
        RUN, P_RD, P_WAIT, R_RD, R_WAIT
    } state_t;

    localparam int CW = $clog2(TX_DEPTH + 1);

    localparam logic [2:0] A_RBR_THR = 3'd0;
    localparam logic [2:0] A_DLM     = 3'd1;
    localparam logic [2:0] A_FCR     = 3'd2;
    localparam logic [2:0] A_LCR     = 3'd3;
    localparam logic [2:0] A_LSR     = 3'd5;

    state_t        state_q, state_d;
    logic [CW-1:0] credits_q, credits_d;
    logic [7:0]    gap_q, gap_d;
    logic          last_q, last_d;
    logic          cfg_done_q;
    logic          rx_valid_q;
    logic [7:0]    rx_data_q;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [2:0]    addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic          poll_due;
    logic [1:0]    pick;
    logic [1:0]    gnt;

    // Round-robin pick among valid requesters and the RUN-only grant
    always_comb begin
        poll_due = (credits_q == '0) || (gap_q == 8'(POLL_GAP)) || (hif.req == 2'b00);
        case (hif.req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_q ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
        gnt = ((state_q == RUN) && !poll_due) ? pick : 2'b00;
    end

    assign hif.gnt = gnt;

    // Next state, counters and the bus access to present in the next cycle
    always_comb begin
        state_d   = state_q;
        credits_d = credits_q;
        gap_d     = gap_q;
        last_d    = last_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        addr_d    = 3'd0;
        din_d     = 8'h00;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = C_DLAB;
                    wr_d    = 1'b1;
                    addr_d  = A_LCR;
                    din_d   = 8'h80;
                end
            end
            C_DLAB: begin
                state_d = C_DLL;
                wr_d    = 1'b1;
                addr_d  = A_RBR_THR;
                din_d   = DIV[7:0];
            end
            C_DLL: begin
                state_d = C_DLM;
                wr_d    = 1'b1;
                addr_d  = A_DLM;
                din_d   = DIV[15:8];
            end
            C_DLM: begin
                state_d = C_LCR;
                wr_d    = 1'b1;
                addr_d  = A_LCR;
                din_d   = LCR_VAL & 8'h7F;
            end
            C_LCR: begin
                state_d = C_FCR;
                wr_d    = 1'b1;
                addr_d  = A_FCR;
                din_d   = FCR_VAL;
            end
            C_FCR: begin
                state_d = RUN;
            end
            RUN: begin
                if (gnt != 2'b00) begin
                    wr_d      = 1'b1;
                    addr_d    = A_RBR_THR;
                    din_d     = gnt[1] ? hif.data1 : hif.data0;
                    credits_d = credits_q - 1'b1;
                    gap_d     = gap_q + 8'd1;
                    last_d    = gnt[1];
                end else begin
                    state_d = P_RD;
                    rd_d    = 1'b1;
                    addr_d  = A_LSR;
                end
            end
            P_RD: begin
                state_d = P_WAIT;
            end
            P_WAIT: begin
                gap_d = 8'd0;
                if (hif.bus_dout[5]) begin
                    credits_d = CW'(TX_DEPTH);
                end
                if (hif.bus_dout[0]) begin
                    state_d = R_RD;
                    rd_d    = 1'b1;
                    addr_d  = A_RBR_THR;
                end else begin
                    state_d = RUN;
                end
            end
            R_RD: begin
                state_d = R_WAIT;
            end
            R_WAIT: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, credit, poll-gap and round-robin history registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            credits_q <= CW'(TX_DEPTH);
            gap_q     <= 8'd0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            gap_q     <= gap_d;
            last_q    <= last_d;
        end
    end

    // Registered bus strobes, address and write data
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            addr_q <= 3'd0;
            din_q  <= 8'h00;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            addr_q <= addr_d;
            din_q  <= din_d;
        end
    end

    // Sticky configuration flag and received-byte capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_done_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            cfg_done_q <= cfg_done_q || (state_d == RUN);
            rx_valid_q <= (state_q == R_WAIT);
            if (state_q == R_WAIT) begin
                rx_data_q <= hif.bus_dout;
            end
        end
    end

    assign cfg_done     = cfg_done_q;
    assign hif.rx_valid = rx_valid_q;
    assign hif.rx_data  = rx_data_q;
    assign hif.bus_wr   = wr_q;
    assign hif.bus_rd   = rd_q;
    assign hif.bus_addr = addr_q;
    assign hif.bus_din  = din_q;

endmodule

// File: tb/tb_uart_host_sequencer.sv
// Bench for uart_host_sequencer: a queue-of-bus-cycles reference model,
// a per-cycle compare process, directed scenarios and a random phase.
module tb_uart_host_sequencer;

    localparam int TX_DEPTH = 16;
    localparam int POLL_GAP = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic cfg_done;
    logic [7:0] lsr_val = 8'h00;
    logic [7:0] rbr_val = 8'h00;

    int vectors = 0;
    int miscompares = 0;
    int rxv_cnt = 0;

    uart_host_sequencer_if hif();

    uart_host_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_done (cfg_done),
        .hif      (hif.master)
    );

    always #5 clk = ~clk;

    // UART register file stand-in: read data valid the cycle after bus_rd
    always @(posedge clk) begin
        if (!rst) hif.bus_dout <= 8'h00;
        else if (hif.bus_rd) hif.bus_dout <= (hif.bus_addr == 3'd5) ? lsr_val : rbr_val;
    end

    // ---------------- reference model ----------------
    // Each entry describes one bus cycle: what is on the bus, whether it
    // belongs to a fixed sequence, and what happens when it closes
    // (1 = LSR sample, 2 = RBR capture, 3 = configuration complete).
    typedef struct {
        bit         sched;
        bit         wr;
        bit         rd;
        logic [2:0] addr;
        logic [7:0] din;
        int         act;
    } cyc_t;

    cyc_t cur;
    cyc_t plan[$];
    int   m_credits = TX_DEPTH;
    int   m_gap = 0;
    bit   m_last = 1'b1;
    bit   m_cfg = 1'b0;
    bit   m_rxv = 1'b0;
    logic [7:0] m_rxd = 8'h00;
    bit   chk_en = 1'b0;

    logic [12:0] ev[$];   // observed accesses {wr, rd, addr, din}

    function automatic cyc_t mk(bit s, bit w, bit r, logic [2:0] a, logic [7:0] d, int act);
        cyc_t c;
        c.sched = s; c.wr = w; c.rd = r; c.addr = a; c.din = d; c.act = act;
        return c;
    endfunction

    function automatic logic [1:0] model_gnt();
        if (!m_cfg || cur.sched) return 2'b00;
        if (m_credits == 0 || m_gap == POLL_GAP || hif.req == 2'b00) return 2'b00;
        if (hif.req == 2'b11) return m_last ? 2'b01 : 2'b10;
        return hif.req;
    endfunction

    initial cur = mk(0, 0, 0, 3'd0, 8'h00, 0);

    always @(posedge clk) begin : model_blk
        logic [1:0] g;
        logic [7:0] dv;
        if (!rst) begin
            plan.delete();
            cur = mk(0, 0, 0, 3'd0, 8'h00, 0);
            m_credits = TX_DEPTH; m_gap = 0; m_last = 1'b1;
            m_cfg = 1'b0; m_rxv = 1'b0; m_rxd = 8'h00;
            chk_en = 1'b1;
        end else begin
            dv = hif.bus_dout;
            g = model_gnt();
            m_rxv = 1'b0;
            case (cur.act)
                1: begin
                    m_gap = 0;
                    if (dv[5]) m_credits = TX_DEPTH;
                    if (dv[0]) begin
                        plan.push_back(mk(1, 0, 1, 3'd0, 8'h00, 0));
                        plan.push_back(mk(1, 0, 0, 3'd0, 8'h00, 2));
                    end
                end
                2: begin m_rxd = dv; m_rxv = 1'b1; end
                3: m_cfg = 1'b1;
                default: ;
            endcase
            if (cur.sched) begin
                cur = (plan.size() > 0) ? plan.pop_front() : mk(0, 0, 0, 3'd0, 8'h00, 0);
            end else if (!m_cfg) begin
                if (start) begin
                    plan.push_back(mk(1, 1, 0, 3'd3, 8'h80, 0));
                    plan.push_back(mk(1, 1, 0, 3'd0, 8'h08, 0));
                    plan.push_back(mk(1, 1, 0, 3'd1, 8'h01, 0));
                    plan.push_back(mk(1, 1, 0, 3'd3, 8'h03, 0));
                    plan.push_back(mk(1, 1, 0, 3'd2, 8'h01, 3));
                    cur = plan.pop_front();
                end else begin
                    cur = mk(0, 0, 0, 3'd0, 8'h00, 0);
                end
            end else if (g != 2'b00) begin
                m_credits = m_credits - 1;
                m_gap = m_gap + 1;
                m_last = g[1];
                cur = mk(0, 1, 0, 3'd0, g[1] ? hif.data1 : hif.data0, 0);
            end else begin
                cur = mk(1, 0, 1, 3'd5, 8'h00, 0);
                plan.push_back(mk(1, 0, 0, 3'd0, 8'h00, 1));
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin : cmp_blk
        logic [1:0] eg;
        if (chk_en) begin
            eg = model_gnt();
            vectors++;
            if (hif.gnt !== eg || hif.bus_wr !== cur.wr || hif.bus_rd !== cur.rd ||
                hif.bus_addr !== cur.addr || hif.bus_din !== cur.din ||
                cfg_done !== m_cfg || hif.rx_valid !== m_rxv || hif.rx_data !== m_rxd) begin
                miscompares++;
                $display("FAIL cycle_check t=%0t: dut gnt=%b wr=%b rd=%b addr=%0d din=%h cfg=%b rxv=%b rxd=%h ; required gnt=%b wr=%b rd=%b addr=%0d din=%h cfg=%b rxv=%b rxd=%h",
                         $time, hif.gnt, hif.bus_wr, hif.bus_rd, hif.bus_addr, hif.bus_din,
                         cfg_done, hif.rx_valid, hif.rx_data,
                         eg, cur.wr, cur.rd, cur.addr, cur.din, m_cfg, m_rxv, m_rxd);
            end
            if (hif.bus_wr || hif.bus_rd)
                ev.push_back({hif.bus_wr, hif.bus_rd, hif.bus_addr, hif.bus_din});
            if (hif.rx_valid) rxv_cnt++;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int req_v);
        vectors++;
        if (got != req_v) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, got, req_v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic check_cfg(input int base);
        logic [12:0] exp_cfg[5];
        exp_cfg[0] = {1'b1, 1'b0, 3'd3, 8'h80};
        exp_cfg[1] = {1'b1, 1'b0, 3'd0, 8'h08};
        exp_cfg[2] = {1'b1, 1'b0, 3'd1, 8'h01};
        exp_cfg[3] = {1'b1, 1'b0, 3'd3, 8'h03};
        exp_cfg[4] = {1'b1, 1'b0, 3'd2, 8'h01};
        for (int i = 0; i < 5; i++) begin
            if (ev.size() > base + i) check($sformatf("cfg_write%0d", i), int'(ev[base + i]), int'(exp_cfg[i]));
            else check($sformatf("cfg_write%0d_missing", i), ev.size(), base + 5);
        end
    endtask

    function automatic int count_thr_writes();
        int n = 0;
        foreach (ev[i]) if (ev[i][12] && ev[i][10:8] == 3'd0) n++;
        return n;
    endfunction

    function automatic int count_all_writes();
        int n = 0;
        foreach (ev[i]) if (ev[i][12]) n++;
        return n;
    endfunction

    function automatic int nth_write_data(input int k);
        int n = 0;
        foreach (ev[i]) begin
            if (ev[i][12]) begin
                if (n == k) return int'(ev[i][7:0]);
                n++;
            end
        end
        return -1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        hif.req = 2'b00;
        hif.data0 = 8'h00;
        hif.data1 = 8'h00;

        // Reset state
        cyc(3);
        check("reset_wr", hif.bus_wr, 0);
        check("reset_addr", hif.bus_addr, 0);
        check("reset_cfg_done", cfg_done, 0);
        check("reset_gnt", hif.gnt, 0);

        // Configuration sequence with default parameters
        rst = 1'b1;
        cyc(1);
        ev.delete();
        do_start();
        cyc(7);
        check_cfg(0);
        check("cfg_done_after_cfg", cfg_done, 1);

        // No THRE ever: fresh credits allow exactly TX_DEPTH writes
        lsr_val = 8'h00;
        hif.data0 = 8'hA0;
        hif.data1 = 8'hB1;
        hif.req = 2'b11;
        ev.delete();
        cyc(80);
        check("credit_limited_writes", count_thr_writes(), TX_DEPTH);
        check("first_tie_req0", nth_write_data(0), 'hA0);
        check("second_write_req1", nth_write_data(1), 'hB1);
        check("no_credit_gnt", hif.gnt, 0);
        lsr_val = 8'h20;
        cyc(30);
        check("grants_resume", count_thr_writes() > TX_DEPTH, 1);

        // Alternating writes with a forced LSR poll every POLL_GAP writes
        do_reset();
        lsr_val = 8'h20;
        ev.delete();
        do_start();
        cyc(30);
        check_cfg(0);
        for (int i = 0; i < POLL_GAP; i++)
            check($sformatf("rr_write%0d", i), (ev.size() > 5 + i) ? int'(ev[5 + i]) : -1,
                  int'({1'b1, 1'b0, 3'd0, (i % 2 == 0) ? 8'hA0 : 8'hB1}));
        check("poll_after_gap", (ev.size() > 13) ? int'(ev[13]) : -1, int'({1'b0, 1'b1, 3'd5, 8'h00}));
        check("write_after_poll", (ev.size() > 14) ? int'(ev[14]) : -1, int'({1'b1, 1'b0, 3'd0, 8'hA0}));

        // Receive draining: no requests, DR always set
        hif.req = 2'b00;
        do_reset();
        lsr_val = 8'h01;
        rbr_val = 8'h5A;
        do_start();
        rxv_cnt = 0;
        cyc(36);
        check("rx_pulses", rxv_cnt >= 4, 1);
        check("rx_data", hif.rx_data, 'h5A);

        // Reset in the middle of configuration, then replay
        do_reset();
        lsr_val = 8'h00;
        do_start();
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("midcfg_reset_wr", hif.bus_wr, 0);
        check("midcfg_reset_din", hif.bus_din, 0);
        check("midcfg_reset_addr", hif.bus_addr, 0);
        rst = 1'b1;
        ev.delete();
        do_start();
        cyc(7);
        check_cfg(0);

        // start while running is ignored
        ev.delete();
        do_start();
        cyc(20);
        check("start_in_run_writes", count_all_writes(), 0);
        check("start_in_run_cfg_done", cfg_done, 1);

        // Random phase against the model
        for (int i = 0; i < 600; i++) begin
            hif.req   = 2'($urandom_range(0, 3));
            hif.data0 = 8'($urandom);
            hif.data1 = 8'($urandom);
            lsr_val   = {2'b00, ($urandom_range(0, 3) != 0), 4'b0000, ($urandom_range(0, 2) == 0)};
            rbr_val   = 8'($urandom);
            start     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 79) != 0);
            cyc(1);
        end
        rst = 1'b1;
        start = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_host_sequencer.md
# uart_host_sequencer

Bus-master controller for the UART 16550 register bus. After `start` it programs the divisor latch, LCR and FCR. It then shares the transmit holding register between two byte requesters using round-robin arbitration, and uses a TX FIFO credit counter to avoid overflowing the 16-deep TX FIFO. It polls LSR to replenish credits and to drain received bytes, and sits directly in front of the UART top's `wr`/`rd`/`addr`/`din`/`dout` pins.

## Interface
- DIV, 16'h0108, divisor; DLL = DIV[7:0], DLM = DIV[15:8]
- LCR_VAL, 8'h03, final LCR value; bit 7 (DLAB) is forced to 0 when written
- FCR_VAL, 8'h01, FCR value; bit 0 enables the FIFOs
- TX_DEPTH, 16, TX FIFO depth; reset and refill value of the credit counter
- POLL_GAP, 8, consecutive THR writes allowed before a forced LSR poll (range 1..255)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-low reset
- start  in  1  begins the configuration sequence; sampled only in IDLE
- cfg_done  out  1  high from the first RUN cycle onward; cleared only by reset
- req  in  2  per-requester byte valid
- data0, data1  in  8  requester bytes
- gnt  out  2  combinational accept; a byte transfers on a cycle with req[i]&gnt[i]
- rx_data  out  8  received byte, held until the next capture
- rx_valid  out  1  one-cycle pulse when rx_data is updated
- bus_wr, bus_rd  out  1  registered register-write / register-read strobes
- bus_addr  out  3  registered register address
- bus_din  out  8  registered write data
- bus_dout  in  8  UART read data

## Operation
- States: IDLE, C_DLAB, C_DLL, C_DLM, C_LCR, C_FCR, RUN, P_RD, P_WAIT, R_RD, R_WAIT.
- IDLE: bus idle. If `start`=1, go to C_DLAB.
- Configuration writes, one per state, each state lasting 1 cycle:
  - C_DLAB: addr 3, data 0x80
  - C_DLL: addr 0, data DIV[7:0]
  - C_DLM: addr 1, data DIV[15:8]
  - C_LCR: addr 3, data LCR_VAL&0x7F
  - C_FCR: addr 2, data FCR_VAL
  - After C_FCR, go to RUN.
- RUN:
  - `poll_due` = (credits==0) | (gap_cnt==POLL_GAP) | (req==0).
  - If not `poll_due`: grant one requester. If only one requester is valid, grant it. If both are valid, grant the one that was not granted last; `last` resets to 1, so requester 0 wins the first tie.
  - On a grant: register bus_wr=1, addr 0, din = granted data; credits−1; gap_cnt+1. Stay in RUN, so back-to-back writes run at 1/cycle.
  - If `poll_due`: gnt=0, go to P_RD.
- P_RD: bus_rd=1, addr 5, for 1 cycle, then go to P_WAIT.
- P_WAIT: sample bus_dout on this cycle's closing edge and clear gap_cnt.
  - If bit5 (THRE) is set, credits=TX_DEPTH.
  - If bit0 (DR) is set, go to R_RD; otherwise go to RUN.
- R_RD: bus_rd=1, addr 0, then go to R_WAIT.
- R_WAIT: capture bus_dout into rx_data, pulse rx_valid next cycle, go to RUN.
- Credit counter:
  - Width is $clog2(TX_DEPTH+1).
  - Never decrements below 0: no grant is issued when credits==0.
  - Refill and decrement never coincide, because grants occur only in RUN.
- A `start` asserted outside IDLE is ignored.
- gnt is never asserted outside RUN, and at most one gnt bit is set per cycle.

## Timing
- Reset (rst=0 at an edge) takes effect that edge, including mid-configuration or mid-poll:
  - state=IDLE
  - cfg_done=0, rx_valid=0, rx_data=0
  - bus_wr=0, bus_rd=0, bus_addr=0, bus_din=0
  - credits=TX_DEPTH, gap_cnt=0, last=1
  - Any in-flight read is abandoned.
- All bus outputs are registered and appear 1 cycle after the state/grant decision. The write strobe is exactly 1 cycle per register access.
- Configuration: start sampled at edge E0; the 5 writes appear in cycles E0+1..E0+5; cfg_done=1 from E0+6.
- Read latency: bus_rd is high in cycle T, and bus_dout is sampled at the end of cycle T+1.
- Full poll without data takes 3 cycles (RUN decision, P_RD, P_WAIT). A poll with data takes 5 cycles.
- Data from `req` to bus_din takes 1 cycle. Requesters must hold data stable while req=1 and gnt=0.

## Test plan
- Reset, then start with default parameters → bus writes (addr,din) = (3,80),(1? no: 0,08),(1,01),(3,03),(2,01) in 5 consecutive cycles; cfg_done rises the next cycle.
- Both req held, data0=A0, data1=B1, LSR returns 0x20 → THR writes A0,B1,A0,B1,... at 1/cycle; an LSR poll (addr 5 read) is inserted after every 8 writes.
- LSR forced to 0x00 (THRE never set), both req held → exactly 16 THR writes, then continuous polling with gnt=0. Setting LSR=0x20 resumes grants after the next P_WAIT.
- req=0, LSR=0x01, RBR=0x5A → continuous polls; each detected DR causes an addr-0 read, rx_data=0x5A and a 1-cycle rx_valid pulse.
- rst=0 asserted during C_DLM → all outputs 0 the next cycle. A subsequent start replays all 5 configuration writes from C_DLAB.
- start pulsed while in RUN → no configuration writes are issued and cfg_done stays 1.
